// File: rtl/cmd_fetch_pkg.sv
// Shared types and constants for the command fetch controller.
package cmd_fetch_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } fetch_state_e;

  // Prefetch buffer depth and the width needed to count 0..FifoDepth.
  localparam int unsigned FifoDepth = 2;
  localparam int unsigned FifoCntW  = $clog2(FifoDepth + 1);
  localparam int unsigned FifoPtrW  = $clog2(FifoDepth);

endpackage

// File: rtl/cmd_fetch_fifo.sv
// Small prefetch FIFO holding fetched commands together with their memory addresses.
module cmd_fetch_fifo
  import cmd_fetch_pkg::*;
#(
  parameter int unsigned CMD_WIDTH  = 128,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [CMD_WIDTH-1:0]  push_data_i,
  input  logic [ADDR_WIDTH-1:0] push_addr_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output logic [FifoCntW-1:0]   count_o,
  output logic [CMD_WIDTH-1:0]  head_data_o,
  output logic [ADDR_WIDTH-1:0] head_addr_o
);

  logic [CMD_WIDTH-1:0]  data_q [FifoDepth];
  logic [ADDR_WIDTH-1:0] addr_q [FifoDepth];
  logic [FifoPtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FifoPtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FifoCntW-1:0]   count_q, count_d;
  logic                  do_push, do_pop;

  // Pointer and occupancy update; flush discards everything, including a same-cycle push.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q < FifoCntW'(FifoDepth)) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + FifoPtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + FifoPtrW'(1);
      count_d = count_q + FifoCntW'(do_push) - FifoCntW'(do_pop);
    end
  end

  // Pointer/count registers and entry storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(FifoDepth); i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush_i) begin
        data_q[wr_ptr_q] <= push_data_i;
        addr_q[wr_ptr_q] <= push_addr_i;
      end
    end
  end

  assign count_o     = count_q;
  assign head_data_o = data_q[rd_ptr_q];
  assign head_addr_o = addr_q[rd_ptr_q];

endmodule

// File: rtl/cmd_fetch_ctrl.sv
// Command fetch controller: streams commands from an external registered-read memory to the
// core through a 2-entry prefetch FIFO, with jump/halt redirects and a host program-load port.
module cmd_fetch_ctrl
  import cmd_fetch_pkg::*;
#(
  parameter int unsigned CMD_WIDTH  = 128,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic                  halt,
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic [CMD_WIDTH-1:0]  cmd,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic                  running,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [CMD_WIDTH-1:0]  host_data,
  output logic                  host_rejected,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [CMD_WIDTH-1:0]  mem_cmd_in,
  input  logic [CMD_WIDTH-1:0]  mem_cmd_out
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_addr_q, inflight_addr_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_wa_q, mem_wa_d;
  logic [CMD_WIDTH-1:0]  mem_wd_q, mem_wd_d;
  logic                  host_rej_q, host_rej_d;

  logic                  is_run, pop, flush, push, issue;
  logic [FifoCntW-1:0]   fifo_count;
  logic [FifoCntW:0]     occupancy;

  // Next-state, fetch pointer, read issue and host-port decisions.
  always_comb begin
    is_run = (state_q == StRun);
    pop    = cmd_valid && cmd_ready;
    // Redirects empty the buffer and drop the read whose data returns this cycle.
    flush  = is_run && (halt || jump_en);
    push   = inflight_q && !flush;
    // Buffered plus returning entries, after this cycle's pop, must leave room for one more.
    occupancy = (FifoCntW + 1)'(fifo_count) + (FifoCntW + 1)'(inflight_q)
              - (FifoCntW + 1)'(pop);
    issue  = is_run && !halt && !jump_en && (occupancy < (FifoCntW + 1)'(FifoDepth));

    state_d = state_q;
    case (state_q)
      StIdle:  if (start && !halt) state_d = StRun;
      StRun:   if (halt) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    ptr_d = ptr_q;
    if (!is_run && start && !halt) begin
      ptr_d = start_addr;
    end else if (is_run && jump_en && !halt) begin
      ptr_d = jump_addr;
    end else if (issue) begin
      ptr_d = ptr_q + ADDR_WIDTH'(1);
    end

    inflight_d      = issue;
    inflight_addr_d = issue ? ptr_q : inflight_addr_q;

    // Program loads only land while idle; otherwise flag the drop for one cycle.
    mem_we_d   = host_we && !is_run;
    host_rej_d = host_we && is_run;
    mem_wa_d   = mem_we_d ? host_addr : mem_wa_q;
    mem_wd_d   = mem_we_d ? host_data : mem_wd_q;
  end

  // Control and host-port registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      ptr_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      mem_we_q        <= 1'b0;
      mem_wa_q        <= '0;
      mem_wd_q        <= '0;
      host_rej_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      mem_we_q        <= mem_we_d;
      mem_wa_q        <= mem_wa_d;
      mem_wd_q        <= mem_wd_d;
      host_rej_q      <= host_rej_d;
    end
  end

  cmd_fetch_fifo #(
    .CMD_WIDTH  (CMD_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (mem_cmd_out),
    .push_addr_i (inflight_addr_q),
    .pop_i       (pop),
    .flush_i     (flush),
    .count_o     (fifo_count),
    .head_data_o (cmd),
    .head_addr_o (cmd_addr)
  );

  assign cmd_valid         = (fifo_count != '0);
  assign running           = (state_q == StRun);
  assign mem_read_address  = ptr_q;
  assign mem_write_enable  = mem_we_q;
  assign mem_write_address = mem_wa_q;
  assign mem_cmd_in        = mem_wd_q;
  assign host_rejected     = host_rej_q;

endmodule

// File: tb/tb_cmd_fetch_ctrl.sv
// Self-checking bench for cmd_fetch_ctrl with a behavioural command memory attached.
module tb_cmd_fetch_ctrl;

  localparam int unsigned CW = 128;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          reset, start, halt, jump_en, cmd_ready, host_we;
  logic [AW-1:0] start_addr, jump_addr, host_addr;
  logic [CW-1:0] host_data;
  logic [CW-1:0] cmd, mem_cmd_in, mem_cmd_out;
  logic [AW-1:0] cmd_addr, mem_read_address, mem_write_address;
  logic          cmd_valid, running, host_rejected, mem_write_enable;

  logic [CW-1:0] tb_mem  [256];
  logic [CW-1:0] ref_mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cmd_fetch_ctrl #(
    .CMD_WIDTH  (CW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .start_addr        (start_addr),
    .halt              (halt),
    .jump_en           (jump_en),
    .jump_addr         (jump_addr),
    .cmd               (cmd),
    .cmd_addr          (cmd_addr),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .running           (running),
    .host_we           (host_we),
    .host_addr         (host_addr),
    .host_data         (host_data),
    .host_rejected     (host_rejected),
    .mem_read_address  (mem_read_address),
    .mem_write_enable  (mem_write_enable),
    .mem_write_address (mem_write_address),
    .mem_cmd_in        (mem_cmd_in),
    .mem_cmd_out       (mem_cmd_out)
  );

  // Attached command memory: registered read, synchronous write.
  always_ff @(posedge clk) begin
    if (mem_write_enable) tb_mem[mem_write_address] <= mem_cmd_in;
    mem_cmd_out <= tb_mem[mem_read_address];
  end

  typedef struct packed {
    logic          start;
    logic [AW-1:0] start_addr;
    logic          halt;
    logic          jump_en;
    logic [AW-1:0] jump_addr;
    logic          ready;
    logic          hw;
    logic [AW-1:0] ha;
    logic [CW-1:0] hd;
    logic          e_valid;
    logic [AW-1:0] e_addr;
    logic [CW-1:0] e_cmd;
    logic          e_running;
    logic          e_rej;
    logic          e_we;
    logic [AW-1:0] e_wa;
    logic [CW-1:0] e_wd;
  } vec_t;

  function automatic vec_t mk(logic st, logic [AW-1:0] sa, logic hl, logic je, logic [AW-1:0] ja,
                              logic rd, logic hw, logic [AW-1:0] ha, logic [CW-1:0] hd,
                              logic ev, logic [AW-1:0] ea, logic er, logic erj,
                              logic ew, logic [AW-1:0] ewa, logic [CW-1:0] ewd);
    vec_t v;
    v.start = st; v.start_addr = sa; v.halt = hl; v.jump_en = je; v.jump_addr = ja;
    v.ready = rd; v.hw = hw; v.ha = ha; v.hd = hd;
    v.e_valid = ev; v.e_addr = ea; v.e_cmd = CW'(8'hA0) + CW'(ea);
    v.e_running = er; v.e_rej = erj; v.e_we = ew; v.e_wa = ewa; v.e_wd = ewd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; start_addr = '0; halt = 1'b0; jump_en = 1'b0; jump_addr = '0;
    cmd_ready = 1'b0; host_we = 1'b0; host_addr = '0; host_data = '0;
  endtask

  task automatic do_start(input logic [AW-1:0] a);
    start = 1'b1; start_addr = a; step(); start = 1'b0;
  endtask

  task automatic do_halt();
    halt = 1'b1; step(); halt = 1'b0;
    chk("halt running", running, 1'b0);
    chk("halt valid", cmd_valid, 1'b0);
  endtask

  vec_t          tbl [11];
  logic [AW-1:0] wrap_exp [4];
  logic [AW-1:0] exp_a, m_exp, m_wa;
  logic [CW-1:0] m_wd;
  logic          m_run, m_stream, m_rej, m_we, xfer, found, seen3;
  int            got, cnt, m_since;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (3) step();
    chk("rst valid", cmd_valid, 1'b0);
    chk("rst running", running, 1'b0);
    chk("rst cmd", cmd, '0);
    chk("rst cmd_addr", cmd_addr, '0);
    chk("rst host_rejected", host_rejected, 1'b0);
    chk("rst mem_we", mem_write_enable, 1'b0);
    chk("rst mem_wa", mem_write_address, '0);
    chk("rst mem_in", mem_cmd_in, '0);
    chk("rst mem_ra", mem_read_address, '0);
    reset = 1'b0;
    step();

    // Preload the whole memory through the host port while idle.
    for (int a = 0; a < 256; a++) begin
      host_we = 1'b1; host_addr = AW'(a);
      host_data = {32'hC0DE_0000 | 32'(a), $urandom, $urandom, $urandom};
      ref_mem[a] = host_data;
      step();
    end
    host_we = 1'b0;
    step();

    // Load 0..3, start together with the last write, stream, reject a write, halt+start.
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 'hA0,   0, 0, 0, 0, 1, 0, 'hA0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 'hA1,   0, 0, 0, 0, 1, 1, 'hA1);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 1, 2, 'hA2,   0, 0, 0, 0, 1, 2, 'hA2);
    tbl[3]  = mk(1, 0, 0, 0, 0, 1, 1, 3, 'hA3,   0, 0, 1, 0, 1, 3, 'hA3);
    tbl[4]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0,      0, 0, 1, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0,      1, 0, 1, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 'hBAD,  1, 1, 1, 1, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0,      1, 2, 1, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0,      1, 3, 1, 0, 0, 0, 0);
    tbl[9]  = mk(1, 0, 1, 0, 0, 1, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 1, 'h40, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      start = tbl[i].start; start_addr = tbl[i].start_addr; halt = tbl[i].halt;
      jump_en = tbl[i].jump_en; jump_addr = tbl[i].jump_addr; cmd_ready = tbl[i].ready;
      host_we = tbl[i].hw; host_addr = tbl[i].ha; host_data = tbl[i].hd;
      step();
      chk($sformatf("row%0d valid", i), cmd_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        chk($sformatf("row%0d cmd_addr", i), cmd_addr, tbl[i].e_addr);
        chk($sformatf("row%0d cmd", i), cmd, tbl[i].e_cmd);
      end
      chk($sformatf("row%0d running", i), running, tbl[i].e_running);
      chk($sformatf("row%0d host_rejected", i), host_rejected, tbl[i].e_rej);
      chk($sformatf("row%0d mem_we", i), mem_write_enable, tbl[i].e_we);
      if (tbl[i].e_we) begin
        chk($sformatf("row%0d mem_wa", i), mem_write_address, tbl[i].e_wa);
        chk($sformatf("row%0d mem_in", i), mem_cmd_in, tbl[i].e_wd);
      end
    end
    idle_inputs();
    for (int a = 0; a < 4; a++) ref_mem[a] = CW'(8'hA0 + a);
    chk("rejected write left memory", tb_mem[0], ref_mem[0]);

    // Address wrap at the top of memory.
    cmd_ready = 1'b1;
    wrap_exp[0] = 8'hFE; wrap_exp[1] = 8'hFF; wrap_exp[2] = 8'h00; wrap_exp[3] = 8'h01;
    do_start(8'hFE);
    got = 0;
    for (int k = 0; k < 20 && got < 4; k++) begin
      if (cmd_valid) begin
        chk($sformatf("wrap addr%0d", got), cmd_addr, wrap_exp[got]);
        chk($sformatf("wrap cmd%0d", got), cmd, ref_mem[wrap_exp[got]]);
        got++;
      end
      step();
    end
    chk("wrap count", got, 4);
    do_halt();

    // Jump while address 2 is being consumed.
    do_start(8'h00);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (cmd_valid && cmd_addr == 8'h02) found = 1'b1;
      else step();
    end
    chk("jump reached addr 2", found, 1'b1);
    jump_en = 1'b1; jump_addr = 8'h10;
    step();
    jump_en = 1'b0;
    chk("jump T+1 valid", cmd_valid, 1'b0);
    step();
    chk("jump T+2 valid", cmd_valid, 1'b0);
    step();
    chk("jump T+3 valid", cmd_valid, 1'b1);
    chk("jump T+3 addr", cmd_addr, 8'h10);
    chk("jump T+3 cmd", cmd, ref_mem[8'h10]);
    seen3 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (cmd_valid && cmd_addr == 8'h03) seen3 = 1'b1;
      step();
    end
    chk("jump skipped addr 3", seen3, 1'b0);
    do_halt();

    // Five-cycle backpressure in the middle of a stream.
    do_start(8'h20);
    exp_a = 8'h20; cnt = 0;
    for (int k = 0; k < 30; k++) begin
      cmd_ready = !(k >= 8 && k <= 12);
      if (cmd_valid) chk("stall outstanding", (8'(mem_read_address - cmd_addr) <= 8'd2), 1'b1);
      if (cmd_valid && cmd_ready) begin
        chk("stall addr", cmd_addr, exp_a);
        exp_a = exp_a + 8'd1;
        cnt++;
      end
      step();
    end
    chk("stall transfers", cnt, 23);
    cmd_ready = 1'b1;
    do_halt();

    // Reset one cycle after the first issue.
    do_start(8'h30);
    step();
    reset = 1'b1;
    step();
    chk("mid rst valid", cmd_valid, 1'b0);
    chk("mid rst running", running, 1'b0);
    chk("mid rst cmd", cmd, '0);
    chk("mid rst cmd_addr", cmd_addr, '0);
    chk("mid rst host_rejected", host_rejected, 1'b0);
    chk("mid rst mem_we", mem_write_enable, 1'b0);
    chk("mid rst mem_wa", mem_write_address, '0);
    chk("mid rst mem_in", mem_cmd_in, '0);
    chk("mid rst mem_ra", mem_read_address, '0);
    reset = 1'b0;
    step();
    chk("post rst valid 1", cmd_valid, 1'b0);
    step();
    chk("post rst valid 2", cmd_valid, 1'b0);
    chk("post rst running", running, 1'b0);

    // Random traffic against a stream-level model: which address must come next and when.
    idle_inputs();
    m_run = 1'b0; m_exp = '0; m_since = 100; m_stream = 1'b0;
    m_rej = 1'b0; m_we = 1'b0; m_wa = '0; m_wd = '0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd running", running, m_run);
      chk("rnd host_rejected", host_rejected, m_rej);
      chk("rnd mem_we", mem_write_enable, m_we);
      if (m_we) begin
        chk("rnd mem_wa", mem_write_address, m_wa);
        chk("rnd mem_in", mem_cmd_in, m_wd);
      end
      if (!m_run || (m_since >= 1 && m_since <= 2)) chk("rnd valid low", cmd_valid, 1'b0);
      else if (m_since == 3 || m_stream) chk("rnd valid high", cmd_valid, 1'b1);
      if (cmd_valid && m_run) begin
        chk("rnd cmd_addr", cmd_addr, m_exp);
        chk("rnd cmd", cmd, ref_mem[m_exp]);
        chk("rnd outstanding", (8'(mem_read_address - cmd_addr) <= 8'd2), 1'b1);
      end

      cmd_ready  = ($urandom_range(0, 3) != 0);
      halt       = ($urandom_range(0, 63) == 0);
      jump_en    = ($urandom_range(0, 15) == 0);
      jump_addr  = AW'($urandom);
      start      = ($urandom_range(0, 7) == 0);
      start_addr = AW'($urandom);
      host_we    = ($urandom_range(0, 15) == 0) && !start;
      host_addr  = AW'($urandom);
      host_data  = {$urandom, $urandom, $urandom, $urandom};

      xfer  = cmd_valid && cmd_ready;
      m_rej = host_we && m_run;
      m_we  = host_we && !m_run;
      if (m_we) begin
        m_wa = host_addr; m_wd = host_data;
        ref_mem[host_addr] = host_data;
      end
      m_stream = 1'b0;
      if (!m_run) begin
        if (start && !halt) begin
          m_run = 1'b1; m_exp = start_addr; m_since = 0;
        end
      end else begin
        if (xfer) m_exp = m_exp + 8'd1;
        if (halt) m_run = 1'b0;
        else if (jump_en) begin
          m_exp = jump_addr; m_since = 0;
        end else m_stream = xfer;
      end
      if (m_since < 100) m_since++;
      step();
    end
    idle_inputs();
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk("final idle", running, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_fetch_ctrl.md
CMD_FETCH_CTRL -- requirements
Module: cmd_fetch_ctrl

Interface
REQ-001 Parameter CMD_WIDTH, default 128, command word width; SHALL match the attached command memory.
REQ-002 Parameter ADDR_WIDTH, default 8, command memory address width; depth is 2**ADDR_WIDTH.
REQ-003 One clock; reset is synchronous and active-high; ports SHALL be named clk and reset.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 start  in  1  pulse; begin fetching at start_addr (honoured in IDLE only).
REQ-007 start_addr  in  ADDR_WIDTH  first fetch address.
REQ-008 halt  in  1  pulse; stop fetching, flush, return to IDLE.
REQ-009 jump_en  in  1  core redirect request (RUN only).
REQ-010 jump_addr  in  ADDR_WIDTH  redirect target.
REQ-011 cmd  out  CMD_WIDTH  command presented to core.
REQ-012 cmd_addr  out  ADDR_WIDTH  memory address of cmd.
REQ-013 cmd_valid  out  1  cmd/cmd_addr valid.
REQ-014 cmd_ready  in  1  core accepts; transfer when cmd_valid & cmd_ready.
REQ-015 running  out  1  high while state is RUN.
REQ-016 host_we, host_addr, host_data  in  1/ADDR_WIDTH/CMD_WIDTH  host program-load port.
REQ-017 host_rejected  out  1  one-cycle pulse: host write dropped because not IDLE.
REQ-018 mem_read_address  out  ADDR_WIDTH  to memory read port (memory registers it).
REQ-019 mem_write_enable, mem_write_address, mem_cmd_in  out  1/ADDR_WIDTH/CMD_WIDTH  to memory write port.
REQ-020 mem_cmd_out  in  CMD_WIDTH  memory read data, valid the cycle after the address is issued.

Function
REQ-021 States: IDLE, RUN; IDLE->RUN on start; RUN->IDLE on halt; halt wins over start and jump_en in the same cycle.
REQ-022 A read is issued in cycle t when state is RUN and (fifo_count + inflight - pop) < 2; mem_read_address = fetch pointer; the pointer increments mod 2**ADDR_WIDTH on each issue (0xFF -> 0x00 at ADDR_WIDTH 8).
REQ-023 Data for a read issued at t SHALL be written into a 2-entry FIFO at the end of t+1 unless discarded; cmd_valid SHALL rise no earlier than t+2.
REQ-024 Start at cycle T: first issue at T+1, cmd_valid at T+3 with cmd_addr = start_addr.
REQ-025 Sustained throughput SHALL be one command per cycle while cmd_ready is held high.
REQ-026 cmd_ready low: FIFO holds; issue stops at 2 entries; no command lost or duplicated.
REQ-027 jump_en at T (RUN): a transfer occurring at T counts as consumed; FIFO flushed at end of T; any read in flight at T discarded; pointer loaded with jump_addr; issue at T+1; cmd_valid low T+1..T+2, high at T+3 with cmd_addr = jump_addr.
REQ-028 halt at T: FIFO flushed, in-flight read discarded, cmd_valid and running low from T+1; no issue from T+1.
REQ-029 start while RUN and jump_en while IDLE SHALL be ignored.
REQ-030 Host write at T in IDLE: mem_write_enable/address/data asserted at T+1 (registered, one cycle).
REQ-031 Host write at T while RUN: no memory write; host_rejected high at T+1 only.
REQ-032 Host write in the same cycle as start (IDLE) SHALL be accepted.

Reset
REQ-033 On reset: state IDLE; FIFO empty; inflight cleared; pointer 0; cmd, cmd_addr, cmd_valid, running, host_rejected, mem_write_enable, mem_write_address, mem_cmd_in, mem_read_address all 0.
REQ-034 Reset mid-RUN SHALL discard in-flight data; a read returning in the cycle after reset SHALL NOT enter the FIFO.

Structure
REQ-035 Package cmd_fetch_pkg SHALL hold the state enum and FIFO depth constant (2).
REQ-036 The 2-entry FIFO SHALL be a sub-module cmd_fetch_fifo (push, pop, flush, count, head data+addr).
REQ-037 cmd_mem SHALL NOT be instantiated inside this block; it connects at the parent.

Verification
REQ-038 Load 0..3 with 0xA0..0xA3 in IDLE, start_addr 0, cmd_ready=1 -> cmd 0xA0..0xA3 on consecutive cycles from T+3.
REQ-039 cmd_ready low 5 cycles mid-stream -> no loss/duplication; at most 2 reads outstanding-or-buffered.
REQ-040 jump_en at addr 2, jump_addr 0x10 -> next valid cmd_addr 0x10 at T+3; no 0x03 ever presented.
REQ-041 start_addr 0xFE, ADDR_WIDTH 8 -> cmd_addr sequence 0xFE, 0xFF, 0x00, 0x01.
REQ-042 Host write while RUN -> host_rejected one pulse, memory contents unchanged; halt+start same cycle in RUN -> IDLE.
REQ-043 reset asserted one cycle after an issue -> all outputs 0 next cycle, FIFO stays empty.
